btn_input_ctrl: RTL and testbench

BTN_INPUT_CTRL -- requirements
Module: btn_input_ctrl

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_debounce.sv | 67 ++++++
 rtl/btn_input_ctrl.sv | 145 ++++++++++++++
 tb/tb_btn_input_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the button input controller
package btn_pkg;

   // Widest supported pin bank; the register file uses only byte lane 0.
   localparam int NUM_IN_MAX = 8;

   // Byte offsets of the four registers; bits [3:2] select the register.
   localparam logic [3:0] ADDR_STATE  = 4'h0;
   localparam logic [3:0] ADDR_RISE   = 4'h4;
   localparam logic [3:0] ADDR_FALL   = 4'h8;
   localparam logic [3:0] ADDR_IRQ_EN = 4'hC;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-pin synchronizer, debounce counter and edge pulses
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic state_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          state_q;
   logic          state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          settle;

   // Two-flop synchronizer; nothing else looks at the raw pad.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing cycles; accept the new level on the last one.
   always_comb begin
      settle  = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sync2_q == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         settle  = 1'b1;
         state_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounced level and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pulses are combinational so the parent latches events on the same edge as the level.
   assign state_o = state_q;
   assign rise_o  = settle &  sync2_q;
   assign fall_o  = settle & ~sync2_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// rtl/btn_input_ctrl.sv - debounced button bank with event registers, irq and bus port
module btn_input_ctrl
   import btn_pkg::*;
#(
   parameter int NUM_IN          = 8,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_IN-1:0] btn_pin,
   input  logic              mem_valid,
   input  logic [3:0]        mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              irq
);

   logic [NUM_IN-1:0] state_w;
   logic [NUM_IN-1:0] rise_ev;
   logic [NUM_IN-1:0] fall_ev;

   logic [NUM_IN-1:0] rise_q, rise_d;
   logic [NUM_IN-1:0] fall_q, fall_d;
   logic [NUM_IN-1:0] irq_en_q, irq_en_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;
   bus_state_e        bus_q, bus_d;

   logic              req_take;
   logic              is_write;
   logic              wr_lane0;
   logic [1:0]        sel;
   logic [NUM_IN-1:0] wr_bits;
   logic [NUM_IN-1:0] clr_rise;
   logic [NUM_IN-1:0] clr_fall;
   logic [NUM_IN-1:0] rd_bits;
   logic              unused_bits;

   genvar g;
   generate
      for (g = 0; g < NUM_IN; g++) begin : g_pin
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk_i  (clk),
            .rst_i  (rst),
            .pin_i  (btn_pin[g]),
            .state_o(state_w[g]),
            .rise_o (rise_ev[g]),
            .fall_o (fall_ev[g])
         );
      end
   endgenerate

   // Only lane 0 carries register bits and the low address bits are don't-care.
   assign unused_bits = ^{mem_wdata[31:NUM_IN], mem_addr[1:0]};

   assign sel      = mem_addr[3:2];
   assign is_write = |mem_wstrb;
   assign wr_lane0 = req_take & is_write & mem_wstrb[0];
   assign wr_bits  = mem_wdata[NUM_IN-1:0];

   // Bus handshake state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_q <= BUS_IDLE;
      end else begin
         bus_q <= bus_d;
      end
   end

   // Accept a request from IDLE, acknowledge for one cycle, then go back.
   always_comb begin
      bus_d    = bus_q;
      req_take = 1'b0;
      case (bus_q)
         BUS_IDLE: begin
            if (mem_valid) begin
               bus_d    = BUS_ACK;
               req_take = 1'b1;
            end
         end
         BUS_ACK: bus_d = BUS_IDLE;
         default: bus_d = BUS_IDLE;
      endcase
   end

   // Register updates: W1C clears lose to a same-cycle event, STATE ignores writes.
   always_comb begin
      clr_rise = '0;
      clr_fall = '0;
      irq_en_d = irq_en_q;
      if (wr_lane0) begin
         if (sel == ADDR_RISE[3:2]) begin
            clr_rise = wr_bits;
         end else if (sel == ADDR_FALL[3:2]) begin
            clr_fall = wr_bits;
         end else if (sel == ADDR_IRQ_EN[3:2]) begin
            irq_en_d = wr_bits;
         end
      end
      rise_d = (rise_q & ~clr_rise) | rise_ev;
      fall_d = (fall_q & ~clr_fall) | fall_ev;
      irq_d  = |((rise_q | fall_q) & irq_en_q);
   end

   // Read mux; rdata is loaded only on an accepted read so it is zero outside ACK.
   always_comb begin
      rd_bits = '0;
      if (sel == ADDR_STATE[3:2]) begin
         rd_bits = state_w;
      end else if (sel == ADDR_RISE[3:2]) begin
         rd_bits = rise_q;
      end else if (sel == ADDR_FALL[3:2]) begin
         rd_bits = fall_q;
      end else begin
         rd_bits = irq_en_q;
      end
      rdata_d = (req_take && !is_write) ? 32'(rd_bits) : 32'd0;
   end

   // Event, enable, read-data and interrupt registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q   <= '0;
         fall_q   <= '0;
         irq_en_q <= '0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         irq_en_q <= irq_en_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   assign mem_ready = (bus_q == BUS_ACK);
   assign mem_rdata = rdata_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// tb/tb_btn_input_ctrl.sv - self-checking bench for btn_input_ctrl
module tb_btn_input_ctrl;
   import btn_pkg::*;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  btn_pin;
   logic        mem_valid;
   logic [3:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        irq;

   always #5 clk = ~clk;

   btn_input_ctrl #(
      .NUM_IN         (8),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_pin  (btn_pin),
      .mem_valid(mem_valid),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .irq      (irq)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int cap_edge = 0;
   int ref_edge = 0;

   // Reference model: a level changes once the last DC synchronized samples all disagree with it.
   logic [7:0]  win[$];
   logic [7:0]  m_s1, m_s2, m_state, m_rise, m_fall, m_en;
   logic        m_irq, m_ack, m_rd_chk;
   logic [31:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [7:0] sv, rev, fev, clr_r, clr_f, r_old, f_old, en_old;
      logic       nirq, all_diff;
      edge_n++;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; win.delete();
         m_state = 0; m_rise = 0; m_fall = 0; m_en = 0;
         m_irq = 0; m_ack = 0; m_rd_chk = 0; m_rd = 0;
         return;
      end
      r_old = m_rise; f_old = m_fall; en_old = m_en;
      nirq  = |((r_old | f_old) & en_old);
      sv = m_s2; m_s2 = m_s1; m_s1 = btn_pin;
      win.push_back(sv);
      if (win.size() > DC) void'(win.pop_front());
      rev = 0; fev = 0;
      for (int i = 0; i < 8; i++) begin
         all_diff = (win.size() == DC);
         foreach (win[k]) if (win[k][i] == m_state[i]) all_diff = 0;
         if (all_diff) begin
            if (m_state[i]) fev[i] = 1'b1;
            else rev[i] = 1'b1;
         end
      end
      clr_r = 0; clr_f = 0; m_rd_chk = 0; m_rd = 0;
      if (!m_ack && mem_valid) begin
         m_ack = 1;
         if (mem_wstrb == 4'h0) begin
            m_rd_chk = 1;
            case (mem_addr[3:2])
               2'd0: m_rd = {24'd0, m_state};
               2'd1: m_rd = {24'd0, r_old};
               2'd2: m_rd = {24'd0, f_old};
               default: m_rd = {24'd0, en_old};
            endcase
         end else if (mem_wstrb[0]) begin
            case (mem_addr[3:2])
               2'd1: clr_r = mem_wdata[7:0];
               2'd2: clr_f = mem_wdata[7:0];
               2'd3: m_en  = mem_wdata[7:0];
               default: ;
            endcase
         end
      end else begin
         m_ack = 0;
      end
      m_state = m_state ^ (rev | fev);
      m_rise  = (r_old & ~clr_r) | rev;
      m_fall  = (f_old & ~clr_f) | fev;
      m_irq   = nirq;
   endtask

   // Every clock edge goes through here: model on posedge, compare on negedge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("ready", 32'(mem_ready), 32'(m_ack));
      if (m_ack && m_rd_chk) chk("rdata", mem_rdata, m_rd);
      else if (!m_ack) chk("rdata_idle", mem_rdata, 32'd0);
   endtask

   task automatic bus(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd);
      int n;
      mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
      n = 0;
      tick();
      while (mem_ready !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk("bus_ready", 32'(mem_ready), 32'd1);
      cap_edge = edge_n;
      rd = mem_rdata;
      mem_valid = 0; mem_wstrb = 0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1; mem_valid = 0; mem_wstrb = 0; mem_addr = 0; mem_wdata = 0; btn_pin = 0;
      repeat (3) tick();
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst = 0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  ws;

      // Reset state of all registers.
      do_reset();
      bus(ADDR_STATE,  0, 4'h0, rd); chk("rst_state",  rd, 32'd0);
      bus(ADDR_RISE,   0, 4'h0, rd); chk("rst_rise",   rd, 32'd0);
      bus(ADDR_FALL,   0, 4'h0, rd); chk("rst_fall",   rd, 32'd0);
      bus(ADDR_IRQ_EN, 0, 4'h0, rd); chk("rst_irq_en", rd, 32'd0);

      // Clean press: level and RISE become visible only after the 2+DC latency.
      for (int ai = 0; ai < 2; ai++) begin
         for (int off = 0; off < 2; off++) begin
            do_reset();
            btn_pin  = 8'h01;
            ref_edge = edge_n;
            if (off != 0) tick();
            for (int k = 0; k < 5; k++) begin
               bus((ai != 0) ? ADDR_RISE : ADDR_STATE, 0, 4'h0, rd);
               chk($sformatf("press_a%0d_rel%0d", ai, cap_edge - ref_edge), rd,
                   (cap_edge - ref_edge > DC + 2) ? 32'd1 : 32'd0);
            end
         end
      end

      // Short pulse on pin 3 is rejected.
      do_reset();
      btn_pin = 8'h08;
      repeat (3) tick();
      btn_pin = 8'h00;
      repeat (10) tick();
      bus(ADDR_STATE, 0, 4'h0, rd); chk("glitch_state", rd, 32'd0);
      bus(ADDR_RISE,  0, 4'h0, rd); chk("glitch_rise",  rd, 32'd0);
      bus(ADDR_FALL,  0, 4'h0, rd); chk("glitch_fall",  rd, 32'd0);

      // Interrupt from pin 2, cleared through both W1C registers.
      do_reset();
      bus(ADDR_IRQ_EN, 32'h04, 4'h1, rd);
      btn_pin = 8'h04;
      repeat (8) tick();
      chk("irq_after_press", 32'(irq), 32'd1);
      btn_pin = 8'h00;
      repeat (8) tick();
      bus(ADDR_RISE, 32'h04, 4'h1, rd);
      chk("irq_fall_pending", 32'(irq), 32'd1);
      bus(ADDR_FALL, 32'h04, 4'h1, rd);
      chk("irq_cleared", 32'(irq), 32'd0);

      // W1C on RISE lands on the same edge pin 1 settles high: event wins.
      do_reset();
      btn_pin = 8'h02;
      repeat (5) tick();
      bus(ADDR_RISE, 32'h02, 4'h1, rd);
      bus(ADDR_RISE, 0, 4'h0, rd); chk("event_wins_rise", rd, 32'h02);

      // Reset during ACK drops the transaction and clears everything.
      do_reset();
      bus(ADDR_IRQ_EN, 32'hFF, 4'h1, rd);
      btn_pin = 8'h81;
      repeat (8) tick();
      mem_valid = 1; mem_addr = ADDR_STATE; mem_wstrb = 4'h0;
      tick();
      chk("ack_before_rst", 32'(mem_ready), 32'd1);
      rst = 1;
      repeat (3) begin
         tick();
         chk("ready_in_rst", 32'(mem_ready), 32'd0);
      end
      mem_valid = 0; btn_pin = 8'h00; rst = 0;
      tick();
      bus(ADDR_STATE,  0, 4'h0, rd); chk("post_rst_state",  rd, 32'd0);
      bus(ADDR_RISE,   0, 4'h0, rd); chk("post_rst_rise",   rd, 32'd0);
      bus(ADDR_FALL,   0, 4'h0, rd); chk("post_rst_fall",   rd, 32'd0);
      bus(ADDR_IRQ_EN, 0, 4'h0, rd); chk("post_rst_irq_en", rd, 32'd0);

      // Back-to-back reads with mem_valid held high.
      do_reset();
      bus(ADDR_IRQ_EN, 32'h5A, 4'h1, rd);
      btn_pin = 8'h33;
      repeat (8) tick();
      mem_valid = 1; mem_addr = ADDR_STATE; mem_wstrb = 4'h0;
      tick();
      chk("b2b_c2_ready", 32'(mem_ready), 32'd1);
      chk("b2b_c2_rdata", mem_rdata, 32'h33);
      mem_addr = ADDR_IRQ_EN;
      tick();
      chk("b2b_c3_ready", 32'(mem_ready), 32'd0);
      tick();
      chk("b2b_c4_ready", 32'(mem_ready), 32'd1);
      chk("b2b_c4_rdata", mem_rdata, 32'h5A);
      mem_valid = 0;
      tick();
      chk("b2b_c5_ready", 32'(mem_ready), 32'd0);
      tick();
      chk("b2b_c6_ready", 32'(mem_ready), 32'd0);

      // Ignored writes: STATE is read-only, IRQ_EN needs lane 0, low address bits don't matter.
      bus(ADDR_STATE, 32'hFF, 4'hF, rd);
      bus(ADDR_STATE, 0, 4'h0, rd); chk("state_ro", rd, 32'h33);
      bus(ADDR_IRQ_EN, 32'hFF, 4'hE, rd);
      bus(4'hF, 0, 4'h0, rd); chk("irq_en_lane0", rd, 32'h5A);

      // Randomized pins and bus traffic against the model.
      do_reset();
      for (int it = 0; it < 700; it++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 5) == 0) btn_pin[b] = ~btn_pin[b];
         end
         if (it % 60 == 0) begin
            repeat (10) tick();
         end else if ($urandom_range(0, 2) == 0) begin
            ws = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus(4'($urandom_range(0, 15)), $urandom, ws, rd);
         end else begin
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
